// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
// rr_pick works on a fixed 8-bit request vector so one function serves every N_REQ.
package ram_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int unsigned MAX_REQ       = 8;
    localparam int unsigned PICK_W        = 3;
    localparam int unsigned DEF_N_REQ     = 4;
    localparam int unsigned DEF_MAX_BURST = 8;
    localparam int unsigned ID_W          = $clog2(DEF_N_REQ);
    localparam int unsigned CNT_W         = $clog2(DEF_MAX_BURST + 1);

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } pick_t;

    // Search starts at last+1 and wraps within the n active requesters.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [PICK_W-1:0]  last,
                                      input int unsigned        n);
        pick_t             p;
        logic [PICK_W-1:0] sel;
        p = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                sel = PICK_W'((32'(last) + k) % n);
                if (!p.found && req[sel]) begin
                    p.found = 1'b1;
                    p.idx   = sel;
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/ram_sig_arbiter_rr.sv
// Combinational round-robin pick over N_REQ requesters.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last,
    output logic             found,
    output logic [IDW-1:0]   idx
);

    pick_t pick;

    always_comb begin
        pick  = rr_pick(MAX_REQ'(req), PICK_W'(last), N_REQ);
        found = pick.found;
        idx   = IDW'(pick.idx);
    end

endmodule

// File: rtl/ram_sig_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between N_REQ requesters,
// with optional locked bursts and a tagged one-cycle read return.
module ram_sig_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned MAX_BURST = 8,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned IDW      = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       req_we,
    input  logic [N_REQ-1:0]       req_lock,
    input  logic [N_REQ*AW-1:0]    req_addr,
    input  logic [N_REQ*WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic                   ram_wren,
    output logic [AW-1:0]          ram_addr,
    output logic [WIDTH-1:0]       ram_din,
    input  logic [WIDTH-1:0]       ram_dout,
    output logic                   rd_valid,
    output logic [IDW-1:0]         rd_id,
    output logic [WIDTH-1:0]       rd_data
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    state_t           state;
    logic [IDW-1:0]   owner;
    logic [IDW-1:0]   last;
    logic [CW-1:0]    burst_cnt;
    logic [WIDTH-1:0] din_q;
    logic             pick_found;
    logic [IDW-1:0]   pick_idx;
    logic [IDW-1:0]   win;
    logic             accept;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req   (req),
        .last  (last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Grant is gated by rst_n so an asserted reset silences the port at once.
    always_comb begin
        gnt    = '0;
        win    = pick_idx;
        accept = pick_found;
        if (state == BURST) begin
            win    = owner;
            accept = req[owner];
        end
        accept = accept & rst_n;
        if (accept) gnt[win] = 1'b1;
        ram_wren = accept & req_we[win];
        ram_addr = accept ? req_addr[AW*int'(win) +: AW] : '0;
        ram_din  = accept ? req_wdata[WIDTH*int'(win) +: WIDTH] : din_q;
    end

    assign rd_data = ram_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            last      <= IDW'(N_REQ - 1);
            burst_cnt <= '0;
            din_q     <= '0;
            rd_valid  <= 1'b0;
            rd_id     <= '0;
        end else begin
            rd_valid <= accept & ~req_we[win];
            if (accept) begin
                last  <= win;
                din_q <= ram_din;
                if (!req_we[win]) rd_id <= win;
            end
            case (state)
                IDLE: begin
                    if (accept && req_lock[win] && (MAX_BURST > 1)) begin
                        state     <= BURST;
                        owner     <= win;
                        burst_cnt <= CW'(1);
                    end
                end
                BURST: begin
                    // Idle release: owner dropped req, last already equals owner.
                    if (!req[owner]) begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end else if (!req_lock[owner] ||
                                 (burst_cnt + CW'(1)) == CW'(MAX_BURST)) begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_sig_arbiter.sv
// Table-driven bench for ram_sig_arbiter with a RAM model and a read-return scoreboard.
module tb_ram_sig_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int AW = 6;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req, req_we, req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*W-1:0]  req_wdata;
    logic [N-1:0]    gnt;
    logic            ram_wren;
    logic [AW-1:0]   ram_addr;
    logic [W-1:0]    ram_din;
    logic [W-1:0]    ram_dout;
    logic            rd_valid;
    logic [1:0]      rd_id;
    logic [W-1:0]    rd_data;

    ram_sig_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(64), .MAX_BURST(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .ram_wren  (ram_wren),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .rd_valid  (rd_valid),
        .rd_id     (rd_id),
        .rd_data   (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM standing in for Ram_Sig.
    logic [W-1:0] mem [64];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    typedef struct {
        logic [3:0]  req, we, lock;
        logic [5:0]  addr;
        logic [15:0] wdata;
        logic [3:0]  gnt;
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
    } rd_t;

    vec_t        vecs[$];
    rd_t         sb[$];
    logic [15:0] ref_mem [64];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] w, input logic [3:0] l,
                       input logic [5:0] a, input logic [15:0] d, input logic [3:0] g);
        vec_t v;
        v.req = r; v.we = w; v.lock = l; v.addr = a; v.wdata = d; v.gnt = g;
        vecs.push_back(v);
    endtask

    // Every read accepted last cycle must come back now, and nothing else.
    task automatic check_rd();
        rd_t e;
        chk("rd_valid", 32'(rd_valid), 32'(sb.size() != 0));
        if (rd_valid && sb.size() != 0) begin
            e = sb.pop_front();
            chk("rd_id", 32'(rd_id), 32'(e.id));
            chk("rd_data", 32'(rd_data), 32'(e.data));
        end
    endtask

    task automatic drive(input vec_t v);
        req = v.req; req_we = v.we; req_lock = v.lock;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = v.addr + 6'(i);
            req_wdata[i*W +: W]  = v.wdata ^ (16'(i) << 12);
        end
    endtask

    task automatic apply(input vec_t v);
        int          w;
        logic [5:0]  ea;
        logic [15:0] ed;
        rd_t         e;
        @(posedge clk); #1;
        drive(v);
        @(negedge clk);
        check_rd();
        chk("gnt", 32'(gnt), 32'(v.gnt));
        if (v.gnt != 4'b0000) begin
            w = 0;
            for (int i = 0; i < N; i++) if (v.gnt[i]) w = i;
            ea = v.addr + 6'(w);
            ed = v.wdata ^ (16'(w) << 12);
            chk("ram_wren", 32'(ram_wren), 32'(v.we[w]));
            chk("ram_addr", 32'(ram_addr), 32'(ea));
            chk("ram_din", 32'(ram_din), 32'(ed));
            if (v.we[w]) ref_mem[ea] = ed;
            else begin
                e.id = 2'(w); e.data = ref_mem[ea];
                sb.push_back(e);
            end
        end else begin
            chk("ram_wren_idle", 32'(ram_wren), 32'(0));
            chk("ram_addr_idle", 32'(ram_addr), 32'(0));
        end
    endtask

    initial begin
        logic [3:0] rot [5];
        vec_t v;
        rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000; rot[4] = 4'b0001;
        for (int i = 0; i < 64; i++) begin mem[i] = '0; ref_mem[i] = '0; end

        // Single read by requester 2 of address 5, then a lone requester 3.
        add(4'b0100, 4'b0000, 4'b0000, 6'd3, 16'h1111, 4'b0100);
        add(4'b1000, 4'b0000, 4'b0000, 6'd10, 16'h1212, 4'b1000);
        // Fairness with all requesting, mixed reads/writes.
        for (int k = 0; k < 5; k++)
            add(4'b1111, 4'b0101, 4'b0000, 6'(20 + k), 16'(16'h2000 + k), rot[k]);
        // Write A5A5 to 7 by requester 0, read it back by requester 1.
        add(4'b0001, 4'b0001, 4'b0000, 6'd7, 16'hA5A5, 4'b0001);
        add(4'b0010, 4'b0000, 4'b0000, 6'd6, 16'h0000, 4'b0010);
        add(4'b0001, 4'b0000, 4'b0000, 6'd30, 16'h3131, 4'b0001);
        // Locked burst by requester 1 capped at 8 beats, then requester 2.
        for (int k = 0; k < 8; k++)
            add(4'b1111, (k % 2 == 1) ? 4'b0010 : 4'b0000, 4'b0010, 6'(32 + k), 16'(16'h3000 + k), 4'b0010);
        add(4'b1111, 4'b0000, 4'b0000, 6'd40, 16'h4040, 4'b0100);
        // Early release by requester 3 on its third beat, then requester 0.
        for (int k = 0; k < 2; k++)
            add(4'b1111, 4'b0000, 4'b1000, 6'(44 + k), 16'(16'h4400 + k), 4'b1000);
        add(4'b1111, 4'b0000, 4'b0000, 6'd46, 16'h4646, 4'b1000);
        add(4'b1111, 4'b0000, 4'b0000, 6'd47, 16'h4747, 4'b0001);
        // Idle release: owner 1 drops req, no beat, then requester 2.
        add(4'b1111, 4'b1000, 4'b0010, 6'd50, 16'h5050, 4'b0010);
        add(4'b1101, 4'b0000, 4'b0010, 6'd51, 16'h5151, 4'b0000);
        add(4'b1101, 4'b0000, 4'b0000, 6'd52, 16'h5252, 4'b0100);
        add(4'b0000, 4'b0000, 4'b0000, 6'd0, 16'h0000, 4'b0000);

        rst_n = 1'b0;
        v.req = '0; v.we = '0; v.lock = '0; v.addr = '0; v.wdata = '0; v.gnt = '0;
        drive(v);
        #2;
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_rd_valid", 32'(rd_valid), 32'(0));
        chk("rst_rd_id", 32'(rd_id), 32'(0));
        chk("rst_ram_wren", 32'(ram_wren), 32'(0));
        chk("rst_ram_addr", 32'(ram_addr), 32'(0));
        chk("rst_ram_din", 32'(ram_din), 32'(0));
        req = 4'b1111;
        #1 chk("rst_gnt_req", 32'(gnt), 32'(0));
        req = '0;
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Reset during beat 4 of a locked burst by requester 3.
        v.req = 4'b1000; v.we = 4'b0000; v.lock = 4'b1000; v.gnt = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            v.addr = 6'(56 + k); v.wdata = 16'(16'h5600 + k);
            apply(v);
        end
        @(posedge clk); #1;
        v.addr = 6'd59;
        drive(v);
        check_rd();
        #1 chk("beat4_gnt", 32'(gnt), 32'(4'b1000));
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'(0));
        chk("midrst_rd_valid", 32'(rd_valid), 32'(0));
        chk("midrst_ram_wren", 32'(ram_wren), 32'(0));
        chk("midrst_ram_addr", 32'(ram_addr), 32'(0));
        sb.delete();
        req = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        v.req = 4'b0110; v.lock = '0; v.addr = 6'd12; v.wdata = 16'h6060; v.gnt = 4'b0010;
        apply(v);
        v.req = '0; v.gnt = '0;
        apply(v);
        apply(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_sig_arbiter.md
# ram_sig_arbiter

Round-robin arbiter that shares one single-port RAM between N_REQ requesters. Each requester can issue single-cycle read or write accesses, or hold the port for a locked burst. The block sits between the requesters and one `Ram_Sig` instance, and owns that RAM's `wren`, `addr` and `data_in`. Read data comes back one cycle after the access, tagged with the requester index.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 16, RAM data width
- DEPTH, 64, RAM depth in words; AW = $clog2(DEPTH)
- MAX_BURST, 8, maximum accepted beats per locked grant; 1 disables locking
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  N_REQ  per-requester access request
- req_we  in  N_REQ  1 = write, 0 = read
- req_lock  in  N_REQ  request to keep the grant after this beat
- req_addr  in  N_REQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  N_REQ*WIDTH  packed write data
- gnt  out  N_REQ  one-hot grant; a beat is accepted when req[i] & gnt[i]
- ram_wren  out  1  to RAM wren
- ram_addr  out  AW  to RAM addr
- ram_din  out  WIDTH  to RAM data_in
- ram_dout  in  WIDTH  from RAM data_out, valid 1 cycle after a read address
- rd_valid  out  1  read data valid
- rd_id  out  $clog2(N_REQ)  requester that owns rd_data
- rd_data  out  WIDTH  read data

## Operation
- State machine with two states.
  - IDLE: no owner.
  - BURST: `owner` register holds the grant.
- Round-robin in IDLE:
  - Search order starts at last+1 mod N_REQ, where `last` is the last accepted requester.
  - The first index with req=1 wins; gnt for the winner is combinational the same cycle.
  - No req means gnt=0.
- On every accepted beat:
  - ram_addr and ram_din come from the winner's slice.
  - ram_wren = req_we of the winner.
  - `last` is updated to the winner.
- IDLE -> BURST when the accepted beat has req_lock=1 and MAX_BURST>1. Then owner = winner and burst_cnt = 1.
- BURST behaviour:
  - gnt = one-hot(owner) & req[owner]; all other requesters are blocked.
  - Each accepted beat increments burst_cnt.
- BURST -> IDLE on any of the following:
  - an accepted beat with req_lock=0;
  - burst_cnt reaches MAX_BURST on an accepted beat;
  - req[owner]=0 for one cycle, which is an idle release. No beat is taken that cycle, and the next cycle re-arbitrates with `last`=owner.
- Read return: a registered flag and index give rd_valid/rd_id one cycle after an accepted read. rd_data = ram_dout passed through combinationally.
- Writes produce no return.
- With no accepted beat:
  - ram_wren = 0 and ram_addr = 0.
  - ram_din holds its last value; ram_din is don't-care.
- burst_cnt width is $clog2(MAX_BURST+1) and it never wraps.
- The RAM never sees a read and a write in the same cycle, because there is only one access per cycle by construction.

## Timing
- Grant latency is 0 cycles: a request in IDLE with no competitor is accepted in the same cycle.
- Read latency is 1 cycle: an accepted read at cycle t gives rd_valid at t+1.
- Back-to-back reads from different requesters give consecutive rd_valid pulses with the matching rd_id.
- Worst-case wait for a requester that holds req continuously is (N_REQ-1)*MAX_BURST cycles.
- Reset values:
  - gnt = 0, ram_wren = 0, ram_addr = 0, ram_din = 0;
  - rd_valid = 0, rd_id = 0;
  - state = IDLE, last = N_REQ-1, so requester 0 has first priority.
- Reset mid-burst: everything returns to IDLE immediately and any pending rd_valid is dropped.
- A requester must hold req, req_we, addr and wdata stable until accepted.

## Structure
- A shared package `ram_arb_pkg` holds:
  - the state enum (IDLE, BURST);
  - localparams for ID width and burst counter width;
  - a function `rr_pick(req, last)` that returns the winner index and a found flag.
- One natural sub-module is `rr_arbiter`: a parameterised combinational round-robin pick. Instantiate it once.
- `Ram_Sig` stays outside this block; the top level connects the two.

## Test plan
- Single read: after reset, req[2]=1, we=0, addr=5 -> gnt=4'b0100 the same cycle, ram_addr=5, next cycle rd_valid=1, rd_id=2, rd_data = mem[5].
- Fairness: req=4'b1111 held with no lock -> grants rotate 0,1,2,3,0 on consecutive cycles.
- Locked burst: requester 1 lock=1 with MAX_BURST=8 while the others request -> exactly 8 consecutive grants to 1, then grant moves to 2.
- Early release: requester 3 lock=1, drops lock on its 3rd beat -> 3 beats, then requester 0 is granted.
- Write then read: requester 0 writes 16'hA5A5 to addr 7, then requester 1 reads addr 7 -> rd_valid with rd_id=1, rd_data=16'hA5A5.
- Reset mid-burst: assert rst_n=0 during beat 4 of a burst -> gnt=0, rd_valid=0 immediately; after release req=4'b0110 -> requester 1 is granted first.
